// File: rtl/fetch_pkg.sv
// Shared types and defaults for the instruction fetch queue.
// Holds the queue entry layout, the fetch FSM encoding and PC helpers.
package fetch_pkg;

    localparam int unsigned DEPTH_DEF     = 4;
    localparam logic [31:0] RESET_PC_DEF  = 32'h0000_0000;
    localparam logic [31:0] PC_STEP       = 32'd4;
    localparam logic [31:0] PC_ALIGN_MASK = 32'hFFFF_FFFC;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } fetch_entry_t;

    typedef enum logic {
        ST_FETCH    = 1'b0,
        ST_REDIRECT = 1'b1
    } fetch_state_t;

    // Force a fetch address onto a word boundary.
    function automatic logic [31:0] align_pc(input logic [31:0] pc);
        return pc & PC_ALIGN_MASK;
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO of fetch entries with flush and a registered head entry.
// The head register always holds the oldest entry so decode sees it without a read mux.
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int unsigned DEPTH = DEPTH_DEF
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   push,
    input  fetch_entry_t           push_data,
    input  logic                   pop,
    input  logic                   flush,
    output logic                   valid,
    output fetch_entry_t           head,
    output logic [$clog2(DEPTH):0] count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    fetch_entry_t  mem [DEPTH];
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_next_c;
    logic [CW-1:0] remain_c;
    logic [CW-1:0] count_next_c;
    logic          do_pop_c;
    logic          do_push_c;

    assign valid        = (count != '0);
    assign do_pop_c     = pop & valid;
    assign do_push_c    = push & ((count != CW'(DEPTH)) | do_pop_c);
    assign rd_next_c    = rd_ptr + AW'(do_pop_c);
    assign remain_c     = count - CW'(do_pop_c);
    assign count_next_c = remain_c + CW'(do_push_c);

    // Storage array carries no reset; only slots below count are ever read.
    always_ff @(posedge clock) begin
        if (!reset && !flush && do_push_c) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            head   <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            rd_ptr <= rd_next_c;
            count  <= count_next_c;
            if (do_push_c) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            // Refill head from storage, or straight from the write port when the queue drains to it.
            if (remain_c != '0) begin
                head <= mem[rd_next_c];
            end else if (do_push_c) begin
                head <= push_data;
            end
        end
    end

endmodule

// File: rtl/fetch_queue.sv
// Instruction fetch front end: issues word fetches under a credit limit and queues responses for decode.
// A redirect flushes the queue, kills the outstanding response and restarts fetch at the new target.
module fetch_queue
    import fetch_pkg::*;
#(
    parameter int unsigned DEPTH    = DEPTH_DEF,
    parameter logic [31:0] RESET_PC = RESET_PC_DEF
) (
    input  logic                   clock,
    input  logic                   reset,
    output logic                   imem_req,
    output logic [31:0]            imem_addr,
    input  logic [31:0]            imem_rdata,
    input  logic                   redirect_valid,
    input  logic [31:0]            redirect_pc,
    output logic                   inst_valid,
    input  logic                   inst_ready,
    output logic [31:0]            instruction_code,
    output logic [31:0]            inst_pc,
    output logic [$clog2(DEPTH):0] count
);

    localparam int unsigned CW = $clog2(DEPTH) + 1;
    localparam int unsigned SW = CW + 1;

    fetch_state_t  state;
    logic [31:0]   fetch_pc;
    logic [31:0]   inflight_pc;
    logic          inflight;
    logic          fifo_valid;
    logic          pop_c;
    logic          push_c;
    logic          credit_ok_c;
    logic [SW-1:0] credit_c;
    fetch_entry_t  push_data_c;
    fetch_entry_t  head;

    // Credit: slots already owed after this cycle's pop must leave room for one more response.
    assign pop_c       = inst_valid & inst_ready;
    assign credit_c    = SW'(count) + SW'(inflight) - SW'(pop_c);
    assign credit_ok_c = (credit_c < SW'(DEPTH));
    assign imem_req    = ~reset & ~redirect_valid & credit_ok_c;
    assign imem_addr   = fetch_pc;

    // A response landing in a redirect cycle belongs to the old stream and is dropped.
    assign push_c = inflight & ~redirect_valid;

    always_comb begin
        push_data_c      = '0;
        push_data_c.pc   = inflight_pc;
        push_data_c.inst = imem_rdata;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= ST_FETCH;
            fetch_pc    <= RESET_PC;
            inflight    <= 1'b0;
            inflight_pc <= '0;
        end else begin
            inflight <= imem_req;
            if (imem_req) begin
                inflight_pc <= fetch_pc;
                fetch_pc    <= fetch_pc + PC_STEP;
            end
            if (redirect_valid) begin
                fetch_pc <= align_pc(redirect_pc);
            end
            case (state)
                ST_FETCH:    state <= redirect_valid ? ST_REDIRECT : ST_FETCH;
                ST_REDIRECT: state <= redirect_valid ? ST_REDIRECT : ST_FETCH;
                default:     state <= ST_FETCH;
            endcase
        end
    end

    fetch_fifo #(
        .DEPTH(DEPTH)
    ) u_fifo (
        .clock     (clock),
        .reset     (reset),
        .push      (push_c),
        .push_data (push_data_c),
        .pop       (pop_c),
        .flush     (redirect_valid),
        .valid     (fifo_valid),
        .head      (head),
        .count     (count)
    );

    // Hold off decode while reset is asserted even though the queue clears on the edge.
    assign inst_valid       = fifo_valid & ~reset;
    assign instruction_code = head.inst;
    assign inst_pc          = head.pc;

endmodule

// File: tb/tb_fetch_queue.sv
// Self-checking bench for fetch_queue: scoreboard of expected fetch stream plus per-scenario checks.
module tb_fetch_queue;

    localparam int unsigned DEPTH   = 4;
    localparam int unsigned CW      = $clog2(DEPTH) + 1;
    localparam logic [31:0] WRAP_PC = 32'hFFFF_FFF8;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic          reset;
    logic          imem_req;
    logic [31:0]   imem_addr;
    logic [31:0]   imem_rdata;
    logic          redirect_valid;
    logic [31:0]   redirect_pc;
    logic          inst_valid;
    logic          inst_ready;
    logic [31:0]   instruction_code;
    logic [31:0]   inst_pc;
    logic [CW-1:0] count;

    logic          w_reset;
    logic          w_imem_req;
    logic [31:0]   w_imem_addr;
    logic [31:0]   w_imem_rdata;
    logic          w_redirect_valid;
    logic [31:0]   w_redirect_pc;
    logic          w_inst_valid;
    logic          w_inst_ready;
    logic [31:0]   w_instruction_code;
    logic [31:0]   w_inst_pc;
    logic [CW-1:0] w_count;

    logic [31:0] mem_xor;
    logic [31:0] exp_pc;
    logic [31:0] exp_q [$];
    int          total;
    int          bad;
    int          pop_count;

    fetch_queue #(.DEPTH(DEPTH), .RESET_PC(32'h0000_0000)) dut (
        .clock            (clock),
        .reset            (reset),
        .imem_req         (imem_req),
        .imem_addr        (imem_addr),
        .imem_rdata       (imem_rdata),
        .redirect_valid   (redirect_valid),
        .redirect_pc      (redirect_pc),
        .inst_valid       (inst_valid),
        .inst_ready       (inst_ready),
        .instruction_code (instruction_code),
        .inst_pc          (inst_pc),
        .count            (count)
    );

    fetch_queue #(.DEPTH(DEPTH), .RESET_PC(WRAP_PC)) dut_w (
        .clock            (clock),
        .reset            (w_reset),
        .imem_req         (w_imem_req),
        .imem_addr        (w_imem_addr),
        .imem_rdata       (w_imem_rdata),
        .redirect_valid   (w_redirect_valid),
        .redirect_pc      (w_redirect_pc),
        .inst_valid       (w_inst_valid),
        .inst_ready       (w_inst_ready),
        .instruction_code (w_instruction_code),
        .inst_pc          (w_inst_pc),
        .count            (w_count)
    );

    // Memory returns a word derived from the address one cycle after the request.
    always @(posedge clock) imem_rdata   <= imem_addr ^ mem_xor;
    always @(posedge clock) w_imem_rdata <= w_imem_addr;

    // Scoreboard: reset and redirect push the expected stream, each decode handshake pops one.
    always @(negedge clock) begin
        if (reset) begin
            exp_q.delete();
            for (int i = 0; i < 64; i++) exp_q.push_back(32'(4 * i));
        end else begin
            if (inst_valid && inst_ready) begin
                pop_count++;
                total++;
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL stream_extra got pc=%h inst=%h, none expected", inst_pc, instruction_code);
                end else begin
                    exp_pc = exp_q.pop_front();
                    if (inst_pc !== exp_pc || instruction_code !== (exp_pc ^ mem_xor)) begin
                        bad++;
                        $display("FAIL stream got pc=%h inst=%h, expected pc=%h inst=%h",
                                 inst_pc, instruction_code, exp_pc, exp_pc ^ mem_xor);
                    end
                end
            end
            if (redirect_valid) begin
                exp_q.delete();
                for (int i = 0; i < 64; i++)
                    exp_q.push_back((redirect_pc & 32'hFFFF_FFFC) + 32'(4 * i));
            end
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; inst_ready = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
        repeat (3) tick();
        #1;
        total++; if (imem_req !== 1'b0) begin bad++; $display("FAIL reset_req got %b, expected 0", imem_req); end
        total++; if (inst_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got %b, expected 0", inst_valid); end
        total++; if (count !== '0) begin bad++; $display("FAIL reset_count got %0d, expected 0", count); end
        total++; if (instruction_code !== 32'h0) begin bad++; $display("FAIL reset_inst got %h, expected 0", instruction_code); end
        total++; if (inst_pc !== 32'h0) begin bad++; $display("FAIL reset_pc got %h, expected 0", inst_pc); end
    endtask

    task automatic test_stream();
        int p0;
        mem_xor = 32'h0;
        tick();
        reset = 1'b0; inst_ready = 1'b1;
        p0 = pop_count;
        for (int i = 0; i < 10; i++) begin
            #1;
            total++;
            if (imem_req !== 1'b1 || imem_addr !== 32'(4 * i)) begin
                bad++; $display("FAIL stream_addr cyc%0d got req=%b addr=%h, expected 1 %h", i, imem_req, imem_addr, 32'(4 * i));
            end
            if (i < 2) begin
                total++;
                if (inst_valid !== 1'b0) begin bad++; $display("FAIL stream_early cyc%0d valid=%b, expected 0", i, inst_valid); end
            end
            if (i == 2) begin
                total++;
                if (inst_valid !== 1'b1 || inst_pc !== 32'h0 || instruction_code !== 32'h0) begin
                    bad++; $display("FAIL stream_first got valid=%b pc=%h inst=%h, expected 1 0 0", inst_valid, inst_pc, instruction_code);
                end
            end
            tick();
        end
        total++;
        if (pop_count - p0 != 8) begin bad++; $display("FAIL stream_rate got %0d pops, expected 8", pop_count - p0); end
    endtask

    task automatic test_backpressure();
        int nreq;
        int p0;
        reset = 1'b1; inst_ready = 1'b0;
        tick(); tick();
        reset = 1'b0;
        nreq = 0;
        for (int i = 0; i < 10; i++) begin
            #1;
            if (imem_req === 1'b1) nreq++;
            tick();
        end
        #1;
        total++; if (nreq != 4) begin bad++; $display("FAIL bp_reqs got %0d, expected 4", nreq); end
        total++; if (count !== CW'(4)) begin bad++; $display("FAIL bp_count got %0d, expected 4", count); end
        total++; if (imem_req !== 1'b0) begin bad++; $display("FAIL bp_stall got %b, expected 0", imem_req); end
        total++; if (inst_valid !== 1'b1 || inst_pc !== 32'h0) begin bad++; $display("FAIL bp_head got %b %h, expected 1 0", inst_valid, inst_pc); end
        tick();
        inst_ready = 1'b1;
        p0 = pop_count;
        #1;
        total++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h10) begin
            bad++; $display("FAIL bp_resume got req=%b addr=%h, expected 1 00000010", imem_req, imem_addr);
        end
        repeat (8) tick();
        total++;
        if (pop_count - p0 != 8) begin bad++; $display("FAIL bp_drain got %0d pops, expected 8", pop_count - p0); end
    endtask

    task automatic test_redirect();
        mem_xor = 32'h5A5A_0000;
        reset = 1'b1; inst_ready = 1'b1;
        tick(); tick();
        reset = 1'b0;
        repeat (4) tick();
        redirect_valid = 1'b1; redirect_pc = 32'h103;
        #1;
        total++; if (imem_req !== 1'b0) begin bad++; $display("FAIL redir_req got %b, expected 0", imem_req); end
        tick();
        redirect_valid = 1'b0; redirect_pc = '0;
        #1;
        total++; if (inst_valid !== 1'b0 || count !== '0) begin bad++; $display("FAIL redir_flush got valid=%b count=%0d, expected 0 0", inst_valid, count); end
        total++; if (imem_req !== 1'b1 || imem_addr !== 32'h100) begin bad++; $display("FAIL redir_addr got %b %h, expected 1 00000100", imem_req, imem_addr); end
        tick(); #1;
        total++; if (inst_valid !== 1'b0) begin bad++; $display("FAIL redir_kill got valid=%b pc=%h, expected 0", inst_valid, inst_pc); end
        tick(); #1;
        total++;
        if (inst_valid !== 1'b1 || inst_pc !== 32'h100 || instruction_code !== (32'h100 ^ mem_xor)) begin
            bad++; $display("FAIL redir_first got %b %h %h, expected 1 00000100 %h", inst_valid, inst_pc, instruction_code, 32'h100 ^ mem_xor);
        end
        repeat (4) tick();
    endtask

    task automatic test_back_to_back();
        redirect_valid = 1'b1; redirect_pc = 32'h200;
        #1;
        total++; if (imem_req !== 1'b0) begin bad++; $display("FAIL b2b_req1 got %b, expected 0", imem_req); end
        tick();
        redirect_pc = 32'h300;
        #1;
        total++; if (imem_req !== 1'b0) begin bad++; $display("FAIL b2b_req2 got %b, expected 0", imem_req); end
        tick();
        redirect_valid = 1'b0; redirect_pc = '0;
        #1;
        total++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h300 || count !== '0) begin
            bad++; $display("FAIL b2b_restart got req=%b addr=%h count=%0d, expected 1 00000300 0", imem_req, imem_addr, count);
        end
        tick(); #1;
        total++; if (inst_valid !== 1'b0) begin bad++; $display("FAIL b2b_gap got %b pc=%h, expected 0", inst_valid, inst_pc); end
        tick(); #1;
        total++; if (inst_valid !== 1'b1 || inst_pc !== 32'h300) begin bad++; $display("FAIL b2b_first got %b %h, expected 1 00000300", inst_valid, inst_pc); end
        repeat (4) tick();
    endtask

    task automatic test_reset_full();
        reset = 1'b1; inst_ready = 1'b0; redirect_valid = 1'b0;
        tick(); tick();
        reset = 1'b0;
        repeat (8) tick();
        #1;
        total++; if (count !== CW'(4)) begin bad++; $display("FAIL rf_full got %0d, expected 4", count); end
        tick();
        reset = 1'b1;
        #1;
        total++; if (imem_req !== 1'b0 || inst_valid !== 1'b0) begin bad++; $display("FAIL rf_during got req=%b valid=%b, expected 0 0", imem_req, inst_valid); end
        tick();
        reset = 1'b0;
        #1;
        total++; if (count !== '0 || inst_valid !== 1'b0) begin bad++; $display("FAIL rf_clear got count=%0d valid=%b, expected 0 0", count, inst_valid); end
        total++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin bad++; $display("FAIL rf_restart got %b %h, expected 1 00000000", imem_req, imem_addr); end
        inst_ready = 1'b1;
        repeat (6) tick();
    endtask

    task automatic test_pc_wrap();
        logic [31:0] exp_addr [5];
        exp_addr = '{32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0000_0000, 32'h0000_0004, 32'h0000_0008};
        w_reset = 1'b0;
        for (int i = 0; i < 5; i++) begin
            #1;
            total++;
            if (w_imem_req !== 1'b1 || w_imem_addr !== exp_addr[i]) begin
                bad++; $display("FAIL wrap_addr cyc%0d got %b %h, expected 1 %h", i, w_imem_req, w_imem_addr, exp_addr[i]);
            end
            if (i == 2) begin
                total++;
                if (w_inst_valid !== 1'b1 || w_inst_pc !== WRAP_PC || w_instruction_code !== WRAP_PC) begin
                    bad++; $display("FAIL wrap_first got %b %h %h, expected 1 %h %h", w_inst_valid, w_inst_pc, w_instruction_code, WRAP_PC, WRAP_PC);
                end
            end
            if (i == 4) begin
                total++;
                if (w_inst_valid !== 1'b1 || w_inst_pc !== 32'h0) begin
                    bad++; $display("FAIL wrap_zero got %b %h, expected 1 00000000", w_inst_valid, w_inst_pc);
                end
            end
            tick();
        end
    endtask

    initial begin
        total = 0; bad = 0; pop_count = 0; mem_xor = '0;
        reset = 1'b1; inst_ready = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
        w_reset = 1'b1; w_inst_ready = 1'b1; w_redirect_valid = 1'b0; w_redirect_pc = '0;
        test_reset();
        test_stream();
        test_backpressure();
        test_redirect();
        test_back_to_back();
        test_reset_full();
        test_pc_wrap();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
